// File: rtl/karat_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | karat_pkg : shared width default and FSM state type for karat_div |
// | Revision  : 1.0                                                   |
// +------------------------------------------------------------------+
package karat_pkg;

  localparam int W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/karat_div_step.sv
`default_nettype none
// +------------------------------------------------------------------+
// | karat_div_step : one combinational restoring-division iteration    |
// | Revision       : 1.0                                               |
// +------------------------------------------------------------------+
module karat_div_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] rem,
  input  logic         q_msb,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] w_s;
  logic [W:0] w_t;

  // rem < divisor always holds, so a restored value never needs bit W.
  always_comb begin
    w_s      = {rem, q_msb};
    w_t      = w_s - {1'b0, divisor};
    q_bit    = ~w_t[W];
    rem_next = q_bit ? w_t[W-1:0] : w_s[W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/karat_div.sv
`default_nettype none
// +------------------------------------------------------------------+
// | karat_div : sequential 2W/W restoring divider, valid/ready I/O     |
// | Revision  : 1.0                                                   |
// +------------------------------------------------------------------+
module karat_div
  import karat_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_zero,
  output logic           overflow
);

  localparam int             CNT_W    = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     q_q, q_d;
  logic [W-1:0]     divisor_q, divisor_d;
  logic [W-1:0]     quotient_q, quotient_d;
  logic [W-1:0]     remainder_q, remainder_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             div_zero_q, div_zero_d;
  logic             overflow_q, overflow_d;

  logic [W-1:0]     w_dividend_hi;
  logic [W-1:0]     w_step_rem;
  logic             w_step_bit;

  assign w_dividend_hi = dividend[2*W-1:W];

  karat_div_step #(.W(W)) u_step (
    .rem      (rem_q),
    .q_msb    (q_q[W-1]),
    .divisor  (divisor_q),
    .rem_next (w_step_rem),
    .q_bit    (w_step_bit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    q_d         = q_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    out_valid_d = out_valid_q;
    div_zero_d  = div_zero_q;
    overflow_d  = overflow_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          divisor_d  = divisor;
          div_zero_d = 1'b0;
          overflow_d = 1'b0;
          if (divisor == '0) begin
            state_d     = DONE;
            div_zero_d  = 1'b1;
            quotient_d  = '0;
            remainder_d = '0;
          end else if (w_dividend_hi >= divisor) begin
            state_d     = DONE;
            overflow_d  = 1'b1;
            quotient_d  = '0;
            remainder_d = '0;
          end else begin
            state_d = RUN;
            rem_d   = w_dividend_hi;
            q_d     = dividend[W-1:0];
            cnt_d   = '0;
          end
        end
      end
      RUN: begin
        rem_d = w_step_rem;
        q_d   = {q_q[W-2:0], w_step_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          quotient_d  = {q_q[W-2:0], w_step_bit};
          remainder_d = w_step_rem;
        end
      end
      DONE: begin
        // Error results enter DONE with out_valid low and raise it one edge later.
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      div_zero_q  <= div_zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_karat_div.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_karat_div : scoreboard bench for karat_div against a reference  |
// | Revision     : 1.0                                                 |
// +------------------------------------------------------------------+
module tb_karat_div;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           div_zero;
  logic           overflow;

  karat_div #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint c;
    longint b;
    longint q;
    longint r;
    bit     dz;
    bit     ov;
    int     lat;
    int     acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: stalled, 2: random
  bit   seen = 1'b0;
  int   hs_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: plain integer division with the divider's error rules.
  function automatic exp_t model(input longint c, input longint b);
    exp_t e;
    e.c = c; e.b = b; e.q = 0; e.r = 0; e.dz = 1'b0; e.ov = 1'b0; e.lat = W; e.acc = 0;
    if (b == 0) begin
      e.dz = 1'b1; e.lat = 1;
    end else if (c / b >= (64'sd1 <<< W)) begin
      e.ov = 1'b1; e.lat = 1;
    end else begin
      e.q = c / b; e.r = c % b;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
      chk("reset_quotient", {48'd0, quotient}, 64'd0);
      chk("reset_flags", {62'd0, div_zero, overflow}, 64'd0);
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q[0];
        if (!seen) begin
          chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
          seen = 1'b1;
        end
        chk("quotient", {48'd0, quotient}, mon_e.q);
        chk("remainder", {48'd0, remainder}, mon_e.r);
        chk("div_zero", {63'd0, div_zero}, {63'd0, mon_e.dz});
        chk("overflow", {63'd0, overflow}, {63'd0, mon_e.ov});
        chk("in_ready_while_valid", {63'd0, in_ready}, 64'd0);
        if (!mon_e.dz && !mon_e.ov) begin
          chk("reconstruct", 64'(quotient) * 64'(mon_e.b) + 64'(remainder), mon_e.c);
          chk("rem_lt_div", {63'd0, (64'(remainder) < 64'(mon_e.b))}, 64'd1);
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          seen   = 1'b0;
          hs_cyc = cyc + 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic issue(input logic [2*W-1:0] c, input logic [W-1:0] b, output int acc);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'd0, 64'd1);
      acc = -1;
      return;
    end
    in_valid = 1'b1;
    dividend = c;
    divisor  = b;
    @(posedge clk);
    #1;
    acc   = cyc;
    e     = model(longint'(c), longint'(b));
    e.acc = cyc;
    exp_q.push_back(e);
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      seen = 1'b0;
    end
  endtask

  initial begin
    int acc;
    int acc2;
    int n;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    int sel;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    rdy_mode = 0;
    issue(32'h0000_0064, 16'h0007, acc); wait_idle();
    issue(32'hFFFE_0001, 16'hFFFF, acc); wait_idle();
    issue(32'h1234_5678, 16'h0000, acc); wait_idle();
    issue(32'h0001_0000, 16'h0001, acc); wait_idle();
    issue(32'h0000_FFFF, 16'h0001, acc); wait_idle();

    // Backpressure then back-to-back acceptance
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    issue(32'h0000_0064, 16'h0007, acc);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", {63'd0, out_valid}, 64'd1);
    repeat (10) @(negedge clk);
    rdy_mode = 0;
    issue(32'hFFFE_0001, 16'hFFFF, acc2);
    chk("back_to_back_accept", 64'(acc2), 64'(hs_cyc + 1));
    wait_idle();

    // Reset in the middle of an operation
    issue(32'h0000_0064, 16'h0007, acc);
    while (cyc < acc + 8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_quotient", {48'd0, quotient}, 64'd0);
    chk("midrst_remainder", {48'd0, remainder}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    exp_q.delete();
    seen = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    issue(32'h0000_0064, 16'h0007, acc); wait_idle();

    // Randomized operations under random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 2500; i++) begin
      sel = $urandom_range(0, 99);
      b   = W'($urandom);
      if (sel < 3) b = '0;
      else if (sel < 10) b = W'($urandom_range(1, 3));
      if (sel >= 3 && sel < 8) hi = W'($urandom);
      else hi = (b == '0) ? W'($urandom) : W'($urandom % b);
      issue({hi, W'($urandom)}, b, acc);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
